hamming_secded_dec_pipe: RTL and testbench

HAMMING_SECDED_DEC_PIPE -- requirements
Module: hamming_secded_dec_pipe

---
 rtl/hamming_pkg.sv | 49 ++++
 rtl/hamming_syndrome.sv | 40 ++++
 rtl/hamming_secded_dec_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_hamming_secded_dec_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
//
// Shared definitions for the Hamming SECDED decoder:
//   calc_r()   - number of Hamming check bits R for K information bits
//                (smallest r with 2^r >= K + r + 1).
//   data_pos() - codeword position (1-based Hamming index) of information
//                bit idx. Check bits sit at power-of-two positions, data bits
//                fill the remaining positions in ascending order.
//   status_e   - decode classification: CLEAN, SEC (single error corrected),
//                DED (uncorrectable error detected).
// -----------------------------------------------------------------------------
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } status_e;

    // Constant function: evaluated at elaboration to size the codeword.
    function automatic int calc_r(input int k);
        int r;
        r = 1;
        while ((1 << r) < (k + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Hamming position of information bit idx. Position 1 and 2 are always
    // check bits, so the scan starts at 3 and skips every power of two.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if ((cnt == idx) && (pos == 0)) begin
                    pos = p;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage : hamming_pkg

// File: rtl/hamming_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
//
// Purely combinational syndrome and overall-parity generator.
//
// Parameters:
//   N - codeword width including the overall-parity bit at index 0
//   R - number of Hamming check bits (syndrome width)
//
// Ports:
//   codeword_i [N-1:0]  bit 0 = overall parity, bit j = Hamming position j
//   syndrome_o [R-1:0]  bit i = XOR of positions 1..N-1 whose index has bit i set
//   parity_o            XOR of all N codeword bits
// -----------------------------------------------------------------------------
module hamming_syndrome #(
    parameter int N = 16,
    parameter int R = 4
) (
    input  logic [N-1:0] codeword_i,
    output logic [R-1:0] syndrome_o,
    output logic         parity_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional update; otherwise an unassigned path infers a latch.
    always_comb begin
        syndrome_o = '0;
        for (int j = 1; j < N; j++) begin
            for (int i = 0; i < R; i++) begin
                if (((j >> i) & 1) != 0) begin
                    syndrome_o[i] = syndrome_o[i] ^ codeword_i[j];
                end
            end
        end
    end

    // Overall parity covers bit 0 too, so a clean codeword yields 0.
    assign parity_o = ^codeword_i;

endmodule : hamming_syndrome

// File: rtl/hamming_secded_dec_pipe.sv
// -----------------------------------------------------------------------------
// hamming_secded_dec_pipe
//
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready
// flow control and optional saturating error counters.
//
//   Stage 1 registers the raw codeword, its syndrome and overall parity.
//   Stage 2 classifies, corrects, extracts the data bits and registers
//   data_o / syndrome_o / sec_o / ded_o. Latency is 2 cycles without stall.
//   Both stages advance together on en = !valid_o || ready_i.
//
// Parameters:
//   K     - information bits (4..57)
//   CNT_W - width of each error counter
//   R, N  - derived: check bits and full codeword width (K + R + 1)
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   codeword_i, valid_i     input codeword and its valid
//   ready_o                 input accepted this cycle (forced 1 in reset)
//   data_o, syndrome_o      corrected data and raw syndrome of that word
//   sec_o, ded_o            single corrected / uncorrectable detected
//   valid_o, ready_i        output valid and downstream ready
//   cnt_clr_i               clear both counters (wins over an increment)
//   sec_cnt_o, ded_cnt_o    saturating counts of SEC / DED output handshakes
//
// Configuration:
//   HAMMING_ERR_CNT_EN - when defined, builds the counters and cnt_clr_i
//                        decode; otherwise counters read 0 and cnt_clr_i is
//                        ignored. The datapath is identical in both builds.
// -----------------------------------------------------------------------------
module hamming_secded_dec_pipe
    import hamming_pkg::*;
#(
    parameter  int K     = 11,
    parameter  int CNT_W = 16,
    localparam int R     = calc_r(K),
    localparam int N     = K + R + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N-1:0]     codeword_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [K-1:0]     data_o,
    output logic [R-1:0]     syndrome_o,
    output logic             sec_o,
    output logic             ded_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] sec_cnt_o,
    output logic [CNT_W-1:0] ded_cnt_o
);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic en;
    logic valid_o_q;

    assign en      = !valid_o_q || ready_i;
    // Reset empties the pipe, so the block is always willing to accept.
    assign ready_o = en || !rst_n_i;

    // ------------------------------------------------------------------
    // Stage 1: syndrome / parity of the incoming word
    // ------------------------------------------------------------------
    logic [R-1:0] syn_d;
    logic         par_d;

    hamming_syndrome #(
        .N (N),
        .R (R)
    ) u_syndrome (
        .codeword_i (codeword_i),
        .syndrome_o (syn_d),
        .parity_o   (par_d)
    );

    logic         s1_valid_q;
    logic [N-1:0] s1_cw_q;
    logic [R-1:0] s1_syn_q;
    logic         s1_par_q;

    // NOTE: the stage-1 payload carries no reset; it is only ever consumed
    // when s1_valid_q is set, and s1_valid_q itself is reset.
    always_ff @(posedge clk_i) begin
        if (en && valid_i) begin
            s1_cw_q  <= codeword_i;
            s1_syn_q <= syn_d;
            s1_par_q <= par_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decode (combinational on stage-1 registers)
    // ------------------------------------------------------------------
    status_e      status_d;
    logic [N-1:0] flip_mask;
    logic [N-1:0] corrected;
    logic [K-1:0] data_d;

    always_comb begin
        status_d  = CLEAN;
        flip_mask = '0;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                // Only the overall-parity bit is wrong; data is intact.
                status_d = SEC;
            end else if (int'(s1_syn_q) <= (N - 1)) begin
                status_d  = SEC;
                flip_mask = N'(1) << s1_syn_q;
            end else begin
                // Syndrome points past the codeword: cannot be a single error.
                status_d = DED;
            end
        end else if (s1_syn_q != '0) begin
            // Even number of flips with non-zero syndrome: double error.
            status_d = DED;
        end
    end

    assign corrected = s1_cw_q ^ flip_mask;

    for (genvar g = 0; g < K; g++) begin : g_extract
        assign data_d[g] = corrected[data_pos(g)];
    end

    // Check-bit positions of the corrected word are intentionally dropped.
    logic unused_corrected;
    assign unused_corrected = ^corrected;

    // ------------------------------------------------------------------
    // Stage 2 and stage valids
    // ------------------------------------------------------------------
    logic [K-1:0] data_q;
    logic [R-1:0] syn_q;
    logic         sec_q;
    logic         ded_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of its inputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            valid_o_q  <= 1'b0;
            data_q     <= '0;
            syn_q      <= '0;
            sec_q      <= 1'b0;
            ded_q      <= 1'b0;
        end else if (en) begin
            s1_valid_q <= valid_i;
            valid_o_q  <= s1_valid_q;
            // A bubble leaves the previous payload in place; only valid drops.
            if (s1_valid_q) begin
                data_q <= data_d;
                syn_q  <= s1_syn_q;
                sec_q  <= (status_d == SEC);
                ded_q  <= (status_d == DED);
            end
        end
    end

    assign valid_o    = valid_o_q;
    assign data_o     = data_q;
    assign syndrome_o = syn_q;
    assign sec_o      = sec_q;
    assign ded_o      = ded_q;

    // ------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------
`ifdef HAMMING_ERR_CNT_EN
    logic             out_hs;
    logic [CNT_W-1:0] sec_cnt_q;
    logic [CNT_W-1:0] ded_cnt_q;

    assign out_hs = valid_o_q && ready_i;

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || cnt_clr_i) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (out_hs) begin
            if (sec_q && (sec_cnt_q != {CNT_W{1'b1}})) begin
                sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            end
            if (ded_q && (ded_cnt_q != {CNT_W{1'b1}})) begin
                ded_cnt_q <= ded_cnt_q + CNT_W'(1);
            end
        end
    end

    assign sec_cnt_o = sec_cnt_q;
    assign ded_cnt_o = ded_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;

    assign sec_cnt_o = '0;
    assign ded_cnt_o = '0;
`endif

endmodule : hamming_secded_dec_pipe

// File: tb/tb_hamming_secded_dec_pipe.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_dec_pipe
//
// Self-checking bench for hamming_secded_dec_pipe at K=11 (N=16, R=4).
// A main instance (CNT_W=16) and a small instance (CNT_W=2) share all inputs.
// Expected words are pushed to a scoreboard queue on input handshake and
// popped on output handshake. Counter expectations follow the build: with
// HAMMING_ERR_CNT_EN undefined, both counters must read 0.
// -----------------------------------------------------------------------------
module tb_hamming_secded_dec_pipe;

`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic [10:0] d;
        logic [15:0] mask;
        logic [10:0] ed;
        logic [3:0]  es;
        logic        sec;
        logic        ded;
    } vec_t;

    typedef struct {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        sec;
        logic        ded;
        logic        lat_chk;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] codeword;
    logic        valid_i;
    logic        ready_i;
    logic        cnt_clr;

    logic        ready_o, sec_o, ded_o, valid_o;
    logic [10:0] data_o;
    logic [3:0]  syn_o;
    logic [15:0] sec_cnt, ded_cnt;

    logic        ready_o_s, sec_o_s, ded_o_s, valid_o_s;
    logic [10:0] data_o_s;
    logic [3:0]  syn_o_s;
    logic [1:0]  sec_cnt_s, ded_cnt_s;

    always #5 clk = ~clk;

    hamming_secded_dec_pipe #(.K(11), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .codeword_i(codeword), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .syndrome_o(syn_o), .sec_o(sec_o),
        .ded_o(ded_o), .valid_o(valid_o), .ready_i(ready_i), .cnt_clr_i(cnt_clr),
        .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt)
    );

    hamming_secded_dec_pipe #(.K(11), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .codeword_i(codeword), .valid_i(valid_i),
        .ready_o(ready_o_s), .data_o(data_o_s), .syndrome_o(syn_o_s), .sec_o(sec_o_s),
        .ded_o(ded_o_s), .valid_o(valid_o_s), .ready_i(ready_i), .cnt_clr_i(cnt_clr),
        .sec_cnt_o(sec_cnt_s), .ded_cnt_o(ded_cnt_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_out   = 0;
    sb_t sb[$];
    sb_t cur;
    int m_sec, m_ded, m_sec_s, m_ded_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent encoder: data to non-power-of-two positions, then check bits.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic        b;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            b = 1'b0;
            for (int p = 1; p < 16; p++) begin
                if ((((p >> i) & 1) != 0) && (p != (1 << i))) b = b ^ c[p];
            end
            c[1 << i] = b;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p];
                k++;
            end
        end
        return d;
    endfunction

    function automatic sb_t mk(input vec_t v, input logic lat);
        sb_t e;
        e.data    = v.ed;
        e.syn     = v.es;
        e.sec     = v.sec;
        e.ded     = v.ded;
        e.lat_chk = lat;
        e.cyc     = 0;
        return e;
    endfunction

    // Monitor / scoreboard: everything sampled on the falling edge, i.e. the
    // values that the next rising edge will act upon.
    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (!rst_n) begin
            m_sec = 0; m_ded = 0; m_sec_s = 0; m_ded_s = 0;
        end else begin
            if (valid_i && ready_o) begin
                e     = cur;
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (valid_o && ready_i) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("data_o", 64'(data_o), 64'(e.data));
                    check("syndrome_o", 64'(syn_o), 64'(e.syn));
                    check("sec_o", 64'(sec_o), 64'(e.sec));
                    check("ded_o", 64'(ded_o), 64'(e.ded));
                    if (e.lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
                    check("sec_cnt", 64'(sec_cnt), 64'(m_sec));
                    check("ded_cnt_s", 64'(ded_cnt_s), 64'(m_ded_s));
                    if (CNT_ON && !cnt_clr) begin
                        if (e.sec) m_sec++;
                        if (e.ded) m_ded++;
                        if (e.sec && m_sec_s != 3) m_sec_s++;
                        if (e.ded && m_ded_s != 3) m_ded_s++;
                    end
                end
            end
            if (cnt_clr) begin
                m_sec = 0; m_ded = 0; m_sec_s = 0; m_ded_s = 0;
            end
        end
    end

    task automatic send(input logic [15:0] cw, input sb_t e);
        logic acc;
        int   waited;
        acc    = 1'b0;
        waited = 0;
        cur      = e;
        codeword = cw;
        valid_i  = 1'b1;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || valid_o) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid_o(input string name);
        logic seen;
        int   w;
        seen = 1'b0;
        w    = 0;
        while (!seen && w < 20) begin
            @(negedge clk);
            seen = valid_o;
            w++;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got t=%0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    vec_t vt[10];

    initial begin
        logic [10:0] held_d;
        logic [3:0]  held_s;
        int          out0;

        rst_n = 1'b0; codeword = '0; valid_i = 1'b0; ready_i = 1'b1; cnt_clr = 1'b0;

        // {data, flip mask, exp data, exp syndrome, sec, ded}
        vt[0] = '{11'h5A3, 16'h0000, 11'h5A3, 4'd0,  1'b0, 1'b0};
        vt[1] = '{11'h5A3, 16'h0040, 11'h5A3, 4'd6,  1'b1, 1'b0};
        vt[2] = '{11'h5A3, 16'h0208, 11'h000, 4'd10, 1'b0, 1'b1};
        vt[3] = '{11'h5A3, 16'h0001, 11'h5A3, 4'd0,  1'b1, 1'b0};
        vt[4] = '{11'h000, 16'h0000, 11'h000, 4'd0,  1'b0, 1'b0};
        vt[5] = '{11'h7FF, 16'h8000, 11'h7FF, 4'd15, 1'b1, 1'b0};
        vt[6] = '{11'h123, 16'h0002, 11'h123, 4'd1,  1'b1, 1'b0};
        vt[7] = '{11'h456, 16'h1020, 11'h000, 4'd9,  1'b0, 1'b1};
        vt[8] = '{11'h3C3, 16'h0081, 11'h000, 4'd7,  1'b0, 1'b1};
        vt[9] = '{11'h2B4, 16'h0800, 11'h2B4, 4'd11, 1'b1, 1'b0};
        // Double errors deliver the uncorrected data bits.
        for (int i = 0; i < 10; i++) begin
            if (vt[i].ded) vt[i].ed = extract(encode(vt[i].d) ^ vt[i].mask);
        end

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_syndrome_o", 64'(syn_o), 64'd0);
        check("rst_sec_ded", 64'({sec_o, ded_o}), 64'd0);
        check("rst_counters", 64'({sec_cnt, ded_cnt}), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);

        // Table vectors, back to back, no stall: latency must be exactly 2.
        for (int i = 0; i < 10; i++) send(encode(vt[i].d) ^ vt[i].mask, mk(vt[i], 1'b1));
        idle();
        drain();
        check("tbl_sec_cnt", 64'(sec_cnt), CNT_ON ? 64'd5 : 64'd0);
        check("tbl_ded_cnt", 64'(ded_cnt), CNT_ON ? 64'd3 : 64'd0);
        check("tbl_sec_cnt_s_sat", 64'(sec_cnt_s), CNT_ON ? 64'd3 : 64'd0);

        // Single SEC word increments the wide counter by exactly one.
        send(encode(vt[1].d) ^ vt[1].mask, mk(vt[1], 1'b1));
        idle();
        drain();
        check("sec_cnt_plus1", 64'(sec_cnt), CNT_ON ? 64'd6 : 64'd0);

        // Five-word stream with a 3-cycle downstream stall.
        out0 = n_out;
        fork
            begin
                for (int i = 3; i < 8; i++) send(encode(vt[i].d) ^ vt[i].mask, mk(vt[i], 1'b0));
                idle();
            end
            begin
                wait_valid_o("stall_wait_valid");
                @(posedge clk); #1;
                ready_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_ready_o", 64'(ready_o), 64'd0);
                    check("stall_valid_o", 64'(valid_o), 64'd1);
                    if (k == 0) begin
                        held_d = data_o;
                        held_s = syn_o;
                    end else begin
                        check("stall_data_held", 64'(data_o), 64'(held_d));
                        check("stall_syn_held", 64'(syn_o), 64'(held_s));
                    end
                end
                @(posedge clk); #1;
                ready_i = 1'b1;
            end
        join
        drain();
        check("stream_delivered", 64'(n_out - out0), 64'd5);

        // Saturation of the 2-bit counter under further SEC events.
        send(encode(vt[5].d) ^ vt[5].mask, mk(vt[5], 1'b1));
        send(encode(vt[6].d) ^ vt[6].mask, mk(vt[6], 1'b1));
        idle();
        drain();
        check("sat_sec_cnt_s", 64'(sec_cnt_s), CNT_ON ? 64'd3 : 64'd0);
        check("sat_sec_cnt", 64'(sec_cnt), CNT_ON ? 64'd11 : 64'd0);

        // Clear coincident with a SEC output handshake: clear wins.
        ready_i = 1'b0;
        send(encode(vt[9].d) ^ vt[9].mask, mk(vt[9], 1'b0));
        idle();
        wait_valid_o("clr_wait_valid");
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        ready_i = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_sec_cnt_s", 64'(sec_cnt_s), 64'd0);
        check("clr_sec_cnt", 64'(sec_cnt), 64'd0);
        check("clr_ded_cnt", 64'(ded_cnt), 64'd0);
        send(encode(vt[3].d) ^ vt[3].mask, mk(vt[3], 1'b1));
        idle();
        drain();
        check("post_clr_sec_cnt_s", 64'(sec_cnt_s), CNT_ON ? 64'd1 : 64'd0);

        // Reset while a word sits stalled at the output.
        ready_i = 1'b0;
        send(encode(vt[7].d) ^ vt[7].mask, mk(vt[7], 1'b0));
        idle();
        wait_valid_o("rst_mid_wait_valid");
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_mid_ready_o", 64'(ready_o), 64'd1);
        @(negedge clk);
        check("rst_mid_valid_o", 64'(valid_o), 64'd0);
        check("rst_mid_data_o", 64'(data_o), 64'd0);
        check("rst_mid_ded_o", 64'(ded_o), 64'd0);
        check("rst_mid_counters", 64'({sec_cnt, ded_cnt}), 64'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        ready_i = 1'b1;
        out0    = n_out;
        cycles(5);
        check("rst_mid_no_output", 64'(n_out - out0), 64'd0);
        send(encode(vt[9].d) ^ vt[9].mask, mk(vt[9], 1'b1));
        idle();
        drain();
        check("rst_mid_recover_out", 64'(n_out - out0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hamming_secded_dec_pipe
